// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the spi_master transaction arbiter.
// rr_pick is sized for the largest supported requester count.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_START,
    ST_WAIT_END,
    ST_GAP
  } arb_state_t;

  localparam int NREQ_MAX    = 8;
  localparam int DEF_DW      = 12;
  localparam int DEF_TO_CYC  = 1023;
  localparam int DEF_GAP_CYC = 2;

  // First valid index at or after ptr, wrapping modulo n; returns ptr when none is valid.
  function automatic logic [2:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                         input logic [2:0] ptr,
                                         input int n);
    logic       found;
    logic [2:0] idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && !found && valid[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin winner selection with a registered priority pointer.
// The pointer moves just past the winner on every accepted request.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic                    accept,
  output logic                    any_valid,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] rr_ptr_next;
  logic [2:0]    pick;

  always_comb begin
    any_valid   = |req_valid;
    pick        = rr_pick(NREQ_MAX'(req_valid), 3'(rr_ptr_reg), NREQ);
    winner      = IW'(pick);
    rr_ptr_next = rr_ptr_reg;
    if (accept) begin
      rr_ptr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master between NREQ requesters: grants round-robin, launches the
// winner's word, follows cs through the transfer and reports done or timeout.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = DEF_DW,
  parameter int TO_CYC  = DEF_TO_CYC,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         req_done,
  output logic [NREQ-1:0]         req_err,
  output logic                    spi_newd,
  output logic [DW-1:0]           spi_din,
  input  logic                    spi_cs,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (TO_CYC > GAP_CYC) ? TO_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TO_LIM  = CW'(TO_CYC);
  localparam logic [CW-1:0] GAP_LIM = CW'(GAP_CYC - 1);

  arb_state_t      state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            cs_sync_reg;
  logic [DW-1:0]   din_reg, din_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic [NREQ-1:0] ready_reg, ready_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic [NREQ-1:0] err_reg, err_next;
  logic            newd_reg, newd_next;
  logic            accept;
  logic            any_valid;
  logic [IW-1:0]   winner;
  logic [DW-1:0]   data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  spi_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .accept    (accept),
    .any_valid (any_valid),
    .winner    (winner)
  );

  // One counter serves both watchdog phases and the gap; it is cleared on each phase entry.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    din_next   = din_reg;
    grant_next = grant_reg;
    ready_next = '0;
    done_next  = '0;
    err_next   = '0;
    newd_next  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_valid) begin
          accept             = 1'b1;
          ready_next[winner] = 1'b1;
          din_next           = data_arr[winner];
          grant_next         = winner;
          state_next         = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        newd_next  = 1'b1;
        cnt_next   = '0;
        state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!cs_sync_reg) begin
          cnt_next   = '0;
          state_next = ST_WAIT_END;
        end else if (cnt_reg >= TO_LIM) begin
          err_next[grant_reg] = 1'b1;
          cnt_next            = '0;
          state_next          = ST_GAP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_WAIT_END: begin
        if (cs_sync_reg) begin
          done_next[grant_reg] = 1'b1;
          cnt_next             = '0;
          state_next           = ST_GAP;
        end else if (cnt_reg >= TO_LIM) begin
          err_next[grant_reg] = 1'b1;
          cnt_next            = '0;
          state_next          = ST_GAP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_reg >= GAP_LIM) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      cs_sync_reg <= 1'b1;
      din_reg     <= '0;
      grant_reg   <= '0;
      ready_reg   <= '0;
      done_reg    <= '0;
      err_reg     <= '0;
      newd_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cs_sync_reg <= spi_cs;
      din_reg     <= din_next;
      grant_reg   <= grant_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      newd_reg    <= newd_next;
    end
  end

  assign req_ready = ready_reg;
  assign req_done  = done_reg;
  assign req_err   = err_reg;
  assign spi_newd  = newd_reg;
  assign spi_din   = din_reg;
  assign grant_id  = grant_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
Shares one spi_master between NREQ independent requesters. Arbitrates round-robin, latches the winner's word, and drives newd/din to the master. Tracks the transfer through the master's cs output and returns a per-requester done or error pulse. Sits between client logic and spi_master, in the same clock domain.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 12, SPI word width; must match spi_master din
TO_CYC, 1023, watchdog limit in clk cycles for each wait phase
GAP_CYC, 2, minimum idle clk cycles between consecutive launches (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NREQ  per-requester request; held until accepted
req_data  input  NREQ*DW  per-requester word; slice i = [i*DW +: DW]
req_ready  output  NREQ  one-cycle accept pulse to the winning requester
req_done  output  NREQ  one-cycle completion pulse to the owner
req_err  output  NREQ  one-cycle timeout pulse to the owner
spi_newd  output  1  one-cycle start strobe to spi_master
spi_din  output  DW  word to spi_master; stable from launch until done
spi_cs  input  1  spi_master chip select, low while shifting
busy  output  1  high in every state except IDLE
grant_id  output  $clog2(NREQ)  index of the current/last owner

Behaviour:
- Reset (rst=0): state=IDLE, rr_ptr=0, grant_id=0, spi_din=0, all pulses 0, busy=0, counters=0. Reset is asynchronous. If it is asserted mid-transfer, the transfer is abandoned and no done/err is emitted.
- States: IDLE, LAUNCH, WAIT_START, WAIT_END, GAP.
- IDLE, any req_valid:
  - Winner = first valid index at or after rr_ptr, wrapping modulo NREQ.
  - Same edge: req_ready[winner]=1 for one cycle, spi_din<=req_data[winner], grant_id<=winner, rr_ptr<=(winner+1)%NREQ, next=LAUNCH.
- LAUNCH: spi_newd=1 for exactly one cycle. Next=WAIT_START with the counter cleared.
- WAIT_START: waits for spi_cs==0.
  - cs low: next=WAIT_END, counter cleared.
  - Counter reaches TO_CYC: req_err[grant_id] pulses, next=GAP.
- WAIT_END: waits for spi_cs==1.
  - cs high: req_done[grant_id] pulses for 1 cycle, next=GAP.
  - Counter reaches TO_CYC: req_err pulses, next=GAP.
  - done and err are mutually exclusive per transfer.
- GAP: counts GAP_CYC cycles, then returns to IDLE. Requests are not sampled during GAP.
- Latency: req_valid seen in IDLE at edge N gives req_ready at N, spi_newd at N+1.
- Simultaneous requests: exactly one grant per transfer, strict round-robin. A continuously valid requester waits at most NREQ-1 transfers.
- Releasing req_valid after accept does not affect the transfer. A requester re-asserting immediately competes in the next IDLE under the updated rr_ptr.
- Watchdog counter is $clog2(TO_CYC+1) bits and saturates; it never wraps.
- spi_cs is not treated as synchronous-by-contract. It is registered once before use, so reaction to cs edges carries one extra cycle.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum typedef (arb_state_t)
  - default DW/TO_CYC constants
  - function rr_pick(valid, ptr) returning the winner index.
- One sub-module, spi_rr_arbiter: combinational round-robin pick plus the registered rr_ptr, parameterised on NREQ. The top holds the FSM, watchdog, and datapath latch.

Test Plan:
1. Single request: req_valid=4'b0100, data 12'hA5C. Expect req_ready[2] at N, spi_newd at N+1, spi_din=12'hA5C, mosi serialises A5C, req_done[2] once after cs rises, grant_id=2.
2. All four requesters valid continuously, rr_ptr=0. Expect grant order 0,1,2,3,0, each with the correct word, and at least GAP_CYC idle cycles between launches.
3. Requesters 1 and 3 valid after grant 1. Expect next grant 3, then 1; no requester is granted twice while another waits.
4. Stuck cs: force spi_cs=1 after launch. Expect req_err[owner] exactly TO_CYC(+1 sync) cycles after entering WAIT_START, no req_done, return to IDLE, next request is served normally.
5. rst low during WAIT_END. Expect immediate IDLE, busy=0, all pulses 0, rr_ptr=0. After release, a new request is granted with no stale done.
6. Back-to-back from requester 0 only, 3 words (12'h001, 12'hFFF, 12'h800). Expect three transfers in order, three done pulses, and spi_din stable during each transfer.
